// File: rtl/alu_op_sequencer.sv
// Command sequencer for data_path: turns one latched ALU command into the
// per-cycle register-file, Y, Z, HI and LO strobes, with all outputs registered.
module alu_op_sequencer (
   input  logic        Clock,
   input  logic        clear,
   input  logic        start,
   input  logic [4:0]  op,
   input  logic [3:0]  ra,
   input  logic [3:0]  rb,
   input  logic [3:0]  rd,
   output logic        busy,
   output logic        done,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        Yin,
   output logic        ZHighin,
   output logic        Zlowin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        LOin,
   output logic        HIin,
   output logic [4:0]  alu_op
);

   localparam logic [4:0] OP_NEG = 5'b01001;
   localparam logic [4:0] OP_NOT = 5'b01010;
   localparam logic [4:0] OP_MUL = 5'b01011;
   localparam logic [4:0] OP_DIV = 5'b01100;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_Y = 3'd1,
      S_EXEC   = 3'd2,
      S_WB_LO  = 3'd3,
      S_WB_HI  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   function automatic logic is_unary(input logic [4:0] o);
      return (o == OP_NEG) || (o == OP_NOT);
   endfunction

   function automatic logic is_wide(input logic [4:0] o);
      return (o == OP_MUL) || (o == OP_DIV);
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  op_q, op_d;
   logic [3:0]  ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic [15:0] rout_q, rout_d, rin_q, rin_d;
   logic        yin_q, yin_d, zhin_q, zhin_d, zlin_q, zlin_d;
   logic        zlout_q, zlout_d, zhout_q, zhout_d, loin_q, loin_d, hiin_q, hiin_d;
   logic [4:0]  alu_op_q, alu_op_d;

   // Next-state and command latch: the command is captured only when leaving IDLE.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rd_d    = rd_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               ra_d    = ra;
               rb_d    = rb;
               rd_d    = rd;
               state_d = is_unary(op) ? S_EXEC : S_LOAD_Y;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD_Y: state_d = S_EXEC;
         S_EXEC:   state_d = S_WB_LO;
         S_WB_LO:  state_d = is_wide(op_q) ? S_WB_HI : S_DONE;
         S_WB_HI:  state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so the registered strobes line up with it.
   always_comb begin
      busy_d   = (state_d != S_IDLE);
      done_d   = 1'b0;
      rout_d   = 16'h0000;
      rin_d    = 16'h0000;
      yin_d    = 1'b0;
      zhin_d   = 1'b0;
      zlin_d   = 1'b0;
      zlout_d  = 1'b0;
      zhout_d  = 1'b0;
      loin_d   = 1'b0;
      hiin_d   = 1'b0;
      alu_op_d = 5'b00000;
      case (state_d)
         S_LOAD_Y: begin
            rout_d = 16'h0001 << ra_d;
            yin_d  = 1'b1;
         end
         S_EXEC: begin
            rout_d   = 16'h0001 << (is_unary(op_d) ? ra_d : rb_d);
            alu_op_d = op_d;
            zhin_d   = 1'b1;
            zlin_d   = 1'b1;
         end
         S_WB_LO: begin
            zlout_d = 1'b1;
            if (is_wide(op_d)) begin
               loin_d = 1'b1;
            end else begin
               rin_d = 16'h0001 << rd_d;
            end
         end
         S_WB_HI: begin
            zhout_d = 1'b1;
            hiin_d  = 1'b1;
         end
         S_DONE:  done_d = 1'b1;
         default: done_d = 1'b0;
      endcase
   end

   // State, command and output registers; clear wipes everything on the same edge.
   always_ff @(posedge Clock) begin
      if (clear) begin
         state_q  <= S_IDLE;
         op_q     <= 5'b00000;
         ra_q     <= 4'h0;
         rb_q     <= 4'h0;
         rd_q     <= 4'h0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rout_q   <= 16'h0000;
         rin_q    <= 16'h0000;
         yin_q    <= 1'b0;
         zhin_q   <= 1'b0;
         zlin_q   <= 1'b0;
         zlout_q  <= 1'b0;
         zhout_q  <= 1'b0;
         loin_q   <= 1'b0;
         hiin_q   <= 1'b0;
         alu_op_q <= 5'b00000;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rd_q     <= rd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rout_q   <= rout_d;
         rin_q    <= rin_d;
         yin_q    <= yin_d;
         zhin_q   <= zhin_d;
         zlin_q   <= zlin_d;
         zlout_q  <= zlout_d;
         zhout_q  <= zhout_d;
         loin_q   <= loin_d;
         hiin_q   <= hiin_d;
         alu_op_q <= alu_op_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign Rout     = rout_q;
   assign Rin      = rin_q;
   assign Yin      = yin_q;
   assign ZHighin  = zhin_q;
   assign Zlowin   = zlin_q;
   assign Zlowout  = zlout_q;
   assign Zhighout = zhout_q;
   assign LOin     = loin_q;
   assign HIin     = hiin_q;
   assign alu_op   = alu_op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: expected per-cycle output bundles are
// queued when a command is issued and compared one per clock.
module tb_alu_op_sequencer;

   logic        Clock, clear, start;
   logic [4:0]  op;
   logic [3:0]  ra, rb, rd;
   logic        busy, done, Yin, ZHighin, Zlowin, Zlowout, Zhighout, LOin, HIin;
   logic [15:0] Rout, Rin;
   logic [4:0]  alu_op;

   alu_op_sequencer dut (
      .Clock(Clock), .clear(clear), .start(start), .op(op),
      .ra(ra), .rb(rb), .rd(rd),
      .busy(busy), .done(done), .Rout(Rout), .Rin(Rin),
      .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
      .Zlowout(Zlowout), .Zhighout(Zhighout),
      .LOin(LOin), .HIin(HIin), .alu_op(alu_op)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // strobe field order: Yin ZHighin Zlowin Zlowout Zhighout LOin HIin
   localparam logic [6:0] S_NONE = 7'b0000000;
   localparam logic [6:0] S_Y    = 7'b1000000;
   localparam logic [6:0] S_Z    = 7'b0110000;
   localparam logic [6:0] S_ZLO  = 7'b0001000;
   localparam logic [6:0] S_ZHO  = 7'b0000100;
   localparam logic [6:0] S_LO   = 7'b0000010;
   localparam logic [6:0] S_HI   = 7'b0000001;

   localparam logic [4:0] ADD = 5'b00011;
   localparam logic [4:0] NEG = 5'b01001;
   localparam logic [4:0] NOT = 5'b01010;
   localparam logic [4:0] MUL = 5'b01011;
   localparam logic [4:0] DIV = 5'b01100;
   localparam logic [4:0] UNK = 5'b11111;

   typedef struct {
      string       tag;
      logic [45:0] v;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   logic [45:0] obs;
   assign obs = {busy, done, Rout, Rin, Yin, ZHighin, Zlowin, Zlowout, Zhighout, LOin, HIin, alu_op};

   function automatic logic [45:0] mk(input logic b, input logic d, input logic [15:0] ro,
                                      input logic [15:0] ri, input logic [6:0] s, input logic [4:0] a);
      return {b, d, ro, ri, s, a};
   endfunction

   task automatic expect_v(input string tag, input logic [45:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      q.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      n_checks++;
      if (q.size() == 0) begin
         n_fails++;
         $error("FAIL scoreboard_empty observed=%h expected=<queued entry>", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.v) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic launch(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
      op    = o;
      ra    = a;
      rb    = b;
      rd    = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      check();
   endtask

   task automatic drain();
      int budget;
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         tick();
         check();
         budget--;
      end
   endtask

   initial begin
      clear = 1'b1;
      start = 1'b1;
      op    = ADD;
      ra    = 4'd3;
      rb    = 4'd4;
      rd    = 4'd5;

      // reset with start held high: nothing latched
      expect_v("reset_c1", mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("reset_c2", mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      tick(); check();
      tick(); check();
      clear = 1'b0;
      start = 1'b0;
      expect_v("idle_after_reset", mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      tick(); check();

      // ADD r5 = r3 + r4
      expect_v("add_load_y", mk(1'b1, 1'b0, 16'h0008, 16'h0000, S_Y, 5'b00000));
      expect_v("add_exec",   mk(1'b1, 1'b0, 16'h0010, 16'h0000, S_Z, ADD));
      expect_v("add_wb_lo",  mk(1'b1, 1'b0, 16'h0000, 16'h0020, S_ZLO, 5'b00000));
      expect_v("add_done",   mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("add_idle",   mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(ADD, 4'd3, 4'd4, 4'd5);
      drain();

      // NEG r6 = -r2, LOAD_Y skipped, rb ignored
      expect_v("neg_exec",  mk(1'b1, 1'b0, 16'h0004, 16'h0000, S_Z, NEG));
      expect_v("neg_wb_lo", mk(1'b1, 1'b0, 16'h0000, 16'h0040, S_ZLO, 5'b00000));
      expect_v("neg_done",  mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("neg_idle",  mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(NEG, 4'd2, 4'd9, 4'd6);
      drain();

      // MUL r1 * r2 into LO/HI
      expect_v("mul_load_y", mk(1'b1, 1'b0, 16'h0002, 16'h0000, S_Y, 5'b00000));
      expect_v("mul_exec",   mk(1'b1, 1'b0, 16'h0004, 16'h0000, S_Z, MUL));
      expect_v("mul_wb_lo",  mk(1'b1, 1'b0, 16'h0000, 16'h0000, S_ZLO | S_LO, 5'b00000));
      expect_v("mul_wb_hi",  mk(1'b1, 1'b0, 16'h0000, 16'h0000, S_ZHO | S_HI, 5'b00000));
      expect_v("mul_done",   mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("mul_idle",   mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(MUL, 4'd1, 4'd2, 4'd7);
      drain();

      // NOT with rd == ra
      expect_v("not_exec",  mk(1'b1, 1'b0, 16'h0080, 16'h0000, S_Z, NOT));
      expect_v("not_wb_lo", mk(1'b1, 1'b0, 16'h0000, 16'h0080, S_ZLO, 5'b00000));
      expect_v("not_done",  mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("not_idle",  mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(NOT, 4'd7, 4'd0, 4'd7);
      drain();

      // DIV with ra == rb == 15
      expect_v("div_load_y", mk(1'b1, 1'b0, 16'h8000, 16'h0000, S_Y, 5'b00000));
      expect_v("div_exec",   mk(1'b1, 1'b0, 16'h8000, 16'h0000, S_Z, DIV));
      expect_v("div_wb_lo",  mk(1'b1, 1'b0, 16'h0000, 16'h0000, S_ZLO | S_LO, 5'b00000));
      expect_v("div_wb_hi",  mk(1'b1, 1'b0, 16'h0000, 16'h0000, S_ZHO | S_HI, 5'b00000));
      expect_v("div_done",   mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("div_idle",   mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(DIV, 4'd15, 4'd15, 4'd3);
      drain();

      // unknown opcode behaves as binary narrow
      expect_v("unk_load_y", mk(1'b1, 1'b0, 16'h0001, 16'h0000, S_Y, 5'b00000));
      expect_v("unk_exec",   mk(1'b1, 1'b0, 16'h0002, 16'h0000, S_Z, UNK));
      expect_v("unk_wb_lo",  mk(1'b1, 1'b0, 16'h0000, 16'h8000, S_ZLO, 5'b00000));
      expect_v("unk_done",   mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("unk_idle",   mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(UNK, 4'd0, 4'd1, 4'd15);
      drain();

      // second start and changed inputs while busy are ignored
      expect_v("busy_load_y", mk(1'b1, 1'b0, 16'h0008, 16'h0000, S_Y, 5'b00000));
      expect_v("busy_exec",   mk(1'b1, 1'b0, 16'h0010, 16'h0000, S_Z, ADD));
      expect_v("busy_wb_lo",  mk(1'b1, 1'b0, 16'h0000, 16'h0020, S_ZLO, 5'b00000));
      expect_v("busy_done",   mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("busy_idle1",  mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("busy_idle2",  mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(ADD, 4'd3, 4'd4, 4'd5);
      start = 1'b1;
      op    = NEG;
      ra    = 4'd9;
      rb    = 4'd10;
      rd    = 4'd11;
      tick(); check();
      tick(); check();
      start = 1'b0;
      drain();

      // clear during WB_LO aborts the write-back and the done pulse
      expect_v("clr_load_y", mk(1'b1, 1'b0, 16'h0008, 16'h0000, S_Y, 5'b00000));
      expect_v("clr_exec",   mk(1'b1, 1'b0, 16'h0010, 16'h0000, S_Z, ADD));
      expect_v("clr_wb_lo",  mk(1'b1, 1'b0, 16'h0000, 16'h0020, S_ZLO, 5'b00000));
      launch(ADD, 4'd3, 4'd4, 4'd5);
      tick(); check();
      tick(); check();
      clear = 1'b1;
      expect_v("clr_abort",  mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      tick(); check();
      clear = 1'b0;
      expect_v("clr_no_done", mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      tick(); check();

      // normal command after the abort
      expect_v("post_exec",  mk(1'b1, 1'b0, 16'h0004, 16'h0000, S_Z, NEG));
      expect_v("post_wb_lo", mk(1'b1, 1'b0, 16'h0000, 16'h0040, S_ZLO, 5'b00000));
      expect_v("post_done",  mk(1'b1, 1'b1, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      expect_v("post_idle",  mk(1'b0, 1'b0, 16'h0000, 16'h0000, S_NONE, 5'b00000));
      launch(NEG, 4'd2, 4'd0, 4'd6);
      drain();

      n_checks++;
      if (q.size() != 0) begin
         n_fails++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Control sequencer for `data_path`. It accepts one ALU command (opcode, two source registers, one destination register) and drives the register-file, Y, Z, HI and LO enable strobes cycle by cycle so the datapath runs the operation without testbench hand-sequencing. It sits between the future instruction decoder and `data_path`, and its outputs connect directly to the datapath's Rout/Rin, Yin, ZHighin/Zlowin, Zlowout/Zhighout, HIin/LOin and op inputs. It replaces per-operation testbench FSMs such as the negate sequence.

Parameters:
- OP_NEG, 5'b01001, negate opcode; unary.
- OP_NOT, 5'b01010, bitwise-not opcode; unary.
- OP_MUL, 5'b01011, multiply opcode; wide result written to LO and HI.
- OP_DIV, 5'b01100, divide opcode; wide result written to LO and HI.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- start  in  1  command valid; sampled only in IDLE.
- op  in  5  ALU opcode, passed to the datapath.
- ra  in  4  source A register index.
- rb  in  4  source B register index; ignored for unary ops.
- rd  in  4  destination register index; ignored for MUL/DIV.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- Rout  out  16  one-hot register output enables (bit n drives Rn-out).
- Rin  out  16  one-hot register load enables (bit n drives Rn-in).
- Yin  out  1  Y register load.
- ZHighin  out  1  Z high half load.
- Zlowin  out  1  Z low half load.
- Zlowout  out  1  Z low half drives the bus.
- Zhighout  out  1  Z high half drives the bus.
- LOin  out  1  LO register load.
- HIin  out  1  HI register load.
- alu_op  out  5  opcode to the datapath ALU; 0 outside EXEC.

Behaviour:
- **States:** IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE. State register is binary; all outputs are registered Moore outputs decoded from state plus latched command.
- **Reset:** clear=1 at a rising edge forces IDLE and all outputs to 0 on that edge, overriding any in-flight operation. No partial write-back completes after clear. The latched command is zeroed.
- **IDLE:**
  - All outputs 0.
  - start=1 latches op/ra/rb/rd.
  - Next state is EXEC if op is OP_NEG or OP_NOT; otherwise LOAD_Y.
  - start=0: remain in IDLE.
- **LOAD_Y:** Rout[ra]=1, Yin=1. Next: EXEC.
- **EXEC:**
  - Rout[rb]=1 for binary ops; Rout[ra]=1 for unary ops.
  - alu_op=latched op; ZHighin=1, Zlowin=1.
  - Next: WB_LO.
- **WB_LO:**
  - Zlowout=1.
  - Rin[rd]=1 for non-wide ops; LOin=1 (Rin all 0) for OP_MUL/OP_DIV.
  - Next: WB_HI if wide, else DONE.
- **WB_HI:** Zhighout=1, HIin=1. Next: DONE.
- **DONE:** done=1 and busy=1 for exactly this one cycle. Next: IDLE. A new start is accepted only after returning to IDLE, so there is a one-cycle gap between commands.
- **Latency from the start-sampling edge to done high:**
  - Unary: 3 cycles (EXEC, WB_LO, DONE).
  - Binary narrow: 4 cycles.
  - Wide: 5 cycles.
- **Busy:** start is ignored while busy. The command is latched once; input changes during an operation have no effect.
- **Bus safety:**
  - At most one bus driver asserted per cycle (one Rout bit, or Zlowout, or Zhighout).
  - Rout and Rin are each 0 or one-hot, never multi-hot.
- **Index edge cases:**
  - ra==rb is legal (the same register is driven in LOAD_Y and EXEC).
  - rd equal to ra or rb is legal; write-back happens after both reads.
- **Unknown opcodes** are treated as binary narrow and forwarded unchanged on alu_op.

Test Plan:
- clear=1 for 2 cycles with start=1 → state IDLE, all outputs 0, busy=0; no command latched.
- ra=3, rb=4, rd=5, op=5'b00011 (ADD), start pulse:
  - next cycle Rout=16'h0008 and Yin=1;
  - then Rout=16'h0010, alu_op=5'b00011, ZHighin=Zlowin=1;
  - then Zlowout=1, Rin=16'h0020;
  - then done=1.
- op=OP_NEG, ra=2, rd=6:
  - LOAD_Y skipped; first active cycle Rout=16'h0004 with alu_op=5'b01001;
  - next Zlowout=1, Rin=16'h0040;
  - done 3 cycles after start.
- op=OP_MUL, ra=1, rb=2:
  - WB_LO asserts LOin=1 with Rin=0;
  - WB_HI asserts Zhighout=1, HIin=1;
  - done 5 cycles after start.
- Second start pulse during EXEC of an ADD → ignored; exactly one done pulse; inputs altered mid-op do not change Rout/Rin.
- clear asserted during WB_LO of an ADD → next cycle all outputs 0, no Rin pulse, no done; a subsequent start runs normally from IDLE.
